gate_unit_sequencer: RTL
========================

# gate_unit_sequencer

Self-test sequencer for the 8-function single-bit gate unit, whose 5-bit select/operand bus is {opcode[2:0], b, a}. On a start pulse it walks all 32 select/operand vectors, waits a programmable dwell per vector, samples the gate's 1-bit output and compares it against an internal golden model. It reports pass/fail, a saturating error count and the first failing vector. It sits between the board control logic and the gate unit and replaces manual switch stepping.

## Interface
- DWELL, 4, cycles each vector is held before sampling; legal range ≥2
- ERR_W, 6, width of error counter
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  run request; sampled only in IDLE
- gate_sel  out  5  drives gate unit select bus: [4:2] opcode, [1] b, [0] a
- gate_out  in  1  gate unit result
- busy  out  1  high while vectors are being applied
- done  out  1  one-cycle pulse at end of run
- pass  out  1  1 = last run had zero mismatches; held until next start
- err_cnt  out  ERR_W  mismatch count of last run, saturating
- fail_vec  out  5  index of first mismatching vector; 0 if none (qualify with pass)

## Operation
- Golden model, a = sel[0], b = sel[1], by opcode:
  - 000: ~a
  - 001: a
  - 010: ~(a^b)
  - 011: a^b
  - 100: a|b
  - 101: ~(a|b)
  - 110: a&b
  - 111: ~(a&b)
- States:
  - IDLE: start=1 → RUN. idx=0, cnt=0; err_cnt, fail_vec and pass cleared on the same edge.
  - RUN: gate_sel=idx. cnt counts 0..DWELL-1. At cnt=DWELL-1, gate_out is compared with golden(idx).
    - Mismatch: err_cnt increments, saturating at 2^ERR_W-1. The first mismatch of the run latches fail_vec=idx.
    - Then: idx=31 → DONE; otherwise idx+1 and cnt=0.
  - DONE: done=1 for one cycle; pass=(err_cnt==0) is registered on entry. Next state is IDLE unconditionally.
- start outside IDLE (RUN or DONE) is ignored; it is not queued.
- gate_sel returns to 0 in IDLE/DONE. err_cnt, fail_vec and pass hold until the next accepted start.
- All outputs are registered.

## Timing
- Reset values: gate_sel=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0; state IDLE.
- start high in cycle T:
  - busy=1 and gate_sel=0 from cycle T+1.
  - Vector k is driven during cycles T+1+k·DWELL … T+(k+1)·DWELL.
  - Vector k is sampled at the edge ending cycle T+(k+1)·DWELL.
- Full run: busy high for 32·DWELL cycles. done=1 and busy=0 in cycle T+32·DWELL+1, with pass/err_cnt/fail_vec valid in that same cycle. IDLE from T+32·DWELL+2, so the earliest new start is sampled there.
- rst_n low mid-run: all outputs take reset values at the next edge; the run is abandoned and no done pulse is produced.
- The gate unit is combinational, so DWELL≥2 gives at least one full settle cycle per vector.

## Configuration
- GATE_SEQ_STOP_ON_ERR_EN:
  - Defined: the first mismatch aborts the run. The sampling edge moves the state to DONE, so err_cnt=1, fail_vec=the failing idx and pass=0, and done fires in the next cycle.
  - Undefined: all 32 vectors are always applied and every mismatch is counted.

## Test plan
- Correct gate model, DWELL=4, start pulse at T → busy for 128 cycles; done in T+129; pass=1, err_cnt=0, fail_vec=0.
- gate_out stuck-at-1, macro undefined → err_cnt=16, fail_vec=5'd1, pass=0.
- Model with only opcode 110 inverted → err_cnt=4, fail_vec=5'd24, pass=0.
- GATE_SEQ_STOP_ON_ERR_EN defined, stuck-at-1, DWELL=4 → done in T+9, err_cnt=1, fail_vec=5'd1, busy low in T+9.
- start re-pulsed while busy → ignored, run length still 128 cycles. rst_n low for one cycle at idx=10 → all outputs 0 at the next edge, no done. A subsequent start → full 128-cycle run with pass=1.
- ERR_W=3, stuck-at-1, macro undefined → err_cnt saturates at 7, pass=0.

Source files
------------

// File: rtl/gate_unit_sequencer_if.sv
// Select/operand bus and status signals between the gate-unit self-test sequencer
// and its neighbours (board control logic and the gate unit itself).
interface gate_unit_sequencer_if #(
   parameter int unsigned ERR_W = 6
);
   logic             start;
   logic [4:0]       gate_sel;
   logic             gate_out;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_cnt;
   logic [4:0]       fail_vec;

   modport master (
      input  start,
      input  gate_out,
      output gate_sel,
      output busy,
      output done,
      output pass,
      output err_cnt,
      output fail_vec
   );

   modport slave (
      output start,
      output gate_out,
      input  gate_sel,
      input  busy,
      input  done,
      input  pass,
      input  err_cnt,
      input  fail_vec
   );
endinterface

// File: rtl/gate_unit_sequencer.sv
// Walks all 32 {opcode, b, a} vectors through the gate unit and checks each result.
// Define GATE_SEQ_STOP_ON_ERR_EN to end the run at the first mismatch.
module gate_unit_sequencer #(
   parameter int unsigned DWELL = 4,
   parameter int unsigned ERR_W = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   gate_unit_sequencer_if.master bus
);

   localparam int unsigned CW = (DWELL > 2) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0]    CntLast = CW'(DWELL - 1);
   localparam logic [ERR_W-1:0] ErrMax  = '1;
   localparam logic [4:0]       IdxLast = 5'd31;

`ifdef GATE_SEQ_STOP_ON_ERR_EN
   localparam bit StopOnErr = 1'b1;
`else
   localparam bit StopOnErr = 1'b0;
`endif

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e           state_q, state_d;
   logic [4:0]       idx_q, idx_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [4:0]       fail_q, fail_d;
   logic             pass_q, pass_d;
   logic [4:0]       sel_q, sel_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             sample;
   logic             mismatch;

   function automatic logic golden(input logic [4:0] sel);
      logic a;
      logic b;
      logic y;
      a = sel[0];
      b = sel[1];
      unique case (sel[4:2])
         3'b000:  y = ~a;
         3'b001:  y = a;
         3'b010:  y = ~(a ^ b);
         3'b011:  y = a ^ b;
         3'b100:  y = a | b;
         3'b101:  y = ~(a | b);
         3'b110:  y = a & b;
         3'b111:  y = ~(a & b);
         default: y = 1'b0;
      endcase
      return y;
   endfunction

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      fail_d   = fail_q;
      pass_d   = pass_q;
      sample   = 1'b0;
      mismatch = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StRun;
               idx_d   = '0;
               cnt_d   = '0;
               err_d   = '0;
               fail_d  = '0;
               pass_d  = 1'b0;
            end
         end

         StRun: begin
            sample   = (cnt_q == CntLast);
            mismatch = sample && (bus.gate_out != golden(idx_q));
            if (mismatch) begin
               if (err_q != ErrMax) begin
                  err_d = err_q + 1'b1;
               end
               // Counter only leaves zero on the first mismatch, so it marks "first".
               if (err_q == '0) begin
                  fail_d = idx_q;
               end
            end
            if (sample) begin
               cnt_d = '0;
               if ((idx_q == IdxLast) || (StopOnErr && mismatch)) begin
                  state_d = StDone;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      // Outputs are registered from the next state so they line up with it.
      busy_d = (state_d == StRun);
      done_d = (state_d == StDone);
      sel_d  = (state_d == StRun) ? idx_d : 5'd0;
      if (state_d == StDone) begin
         pass_d = (err_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         fail_q  <= '0;
         pass_q  <= 1'b0;
         sel_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         fail_q  <= fail_d;
         pass_q  <= pass_d;
         sel_q   <= sel_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.gate_sel = sel_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.pass     = pass_q;
   assign bus.err_cnt  = err_q;
   assign bus.fail_vec = fail_q;

endmodule
